kram_loader: RTL and testbench
==============================

// Module: kram_loader
// PURPOSE
//  Write-side producer for the KRAM BRAM array. Accepts a valid/ready stream of kernel
//  words and writes it into one KRAM slot (PE_NUM banks) through the BRAM write port.
//  Words are striped across the slot's banks: lane = i % PE_NUM, row = i / PE_NUM.
//  CU reads one slot while this block refills the other (ping-pong weight buffering).
// PARAMETERS
//  PE_NUM   8   banks per slot; KRAM has 2*PE_NUM banks; power of two
//  DATA_W   16  bits per kernel word (= `DATA_RANGE width)
//  BANK_AW  10  address bits per bank (= `KRAM_BANKADDR_RANGE width)
// PORTS
//  clk        in   1          clock
//  rst        in   1          async reset, active-high
//  start      in   1          1-cycle load request; sampled in IDLE only
//  slot       in   1          target slot for this load
//  rows       in   BANK_AW+1  rows to load; total words = rows*PE_NUM
//  cu_slot    in   1          slot currently read by CU (kram_router slot_sel)
//  s_valid    in   1          stream word valid
//  s_ready    out  1          stream word accepted when s_valid & s_ready
//  s_data     in   DATA_W     stream word
//  bram_addr  out  BANK_AW    row address, broadcast to all banks
//  bram_wdata out  DATA_W     write data, broadcast to all banks
//  bram_we    out  2*PE_NUM   per-bank write enable; at most one bit set
//  bram_en    out  2*PE_NUM   per-bank enable; equals bram_we
//  busy       out  1          high from accepted start until done
//  done       out  1          1-cycle pulse with the final write
//  err        out  1          1-cycle pulse: start rejected, slot == cu_slot
// BEHAVIOUR
//  Reset: state=IDLE; s_ready, busy, done, err, bram_we, bram_en = 0.
//         bram_addr and bram_wdata = 0. Lane and row counters = 0.
//  FSM IDLE -> LOAD -> LAST -> IDLE.
//  IDLE:
//   - start & slot==cu_slot: err pulses next cycle; stay in IDLE.
//   - start & slot!=cu_slot & rows==0: done pulses next cycle; no writes; stay in IDLE.
//   - start & slot!=cu_slot & rows!=0: latch slot and rows; clear counters; go to LOAD;
//     busy rises next cycle.
//  LOAD:
//   - s_ready=1. Each handshake registers one write; outputs are valid in the next cycle:
//     bram_we[slot*PE_NUM+lane]=1, bram_addr=row, bram_wdata=s_data.
//   - Write latency from handshake to bram_we is 1 cycle. No handshake means all we=0.
//   - After each handshake lane increments. When lane wraps at PE_NUM-1, lane=0 and row++.
//   - Handshake at lane==PE_NUM-1 and row==rows-1 is the last word; go to LAST.
//  LAST (1 cycle):
//   - s_ready=0; the final write is on the bus; done=1; busy=0 next cycle; go to IDLE.
//  s_ready is a registered function of state only (high exactly in LOAD).
//   - It does not depend on s_valid.
//   - Throughput is 1 word/cycle.
//  start while busy: ignored, with no err.
//  cu_slot changes to the loading slot during LOAD: no abort; integrity is the
//   scheduler's responsibility.
//  bram_en mirrors bram_we; banks of the other slot are never driven (we=en=0).
//  rows max = 2^BANK_AW. Row counter is BANK_AW+1 bits wide; bram_addr = row[BANK_AW-1:0].
//  Async rst mid-LOAD: all outputs return to reset values immediately; the partial load
//   is discarded; no done.
// TESTING (PE_NUM=4, DATA_W=16, BANK_AW=10)
//  1. cu_slot=0, start slot=1 rows=2, 8 back-to-back words 0x10..0x17:
//     -> bank4..7 row0 = 10..13; bank4..7 row1 = 14..17.
//     -> done occurs 1 cycle after the last handshake; busy=0 afterwards.
//  2. Same load with s_valid toggling 1010...:
//     -> identical bank contents; no we in idle gaps; one we bit per write.
//  3. start slot=0 while cu_slot=0 -> err=1 for 1 cycle; busy, s_ready, and we stay 0.
//  4. start rows=0 -> done pulse next cycle; no bram_we; s_ready stays 0.
//  5. rst asserted after 3 of 8 words -> same cycle: we=0, busy=0, s_ready=0.
//     -> new load then starts at lane0/row0.
//  6. rows=1024 full-depth load -> last write is bank slot*4+3 at addr 0x3FF; done pulses;
//     start during busy ignored.

Source files
------------

// File: rtl/kram_loader.sv
// Write-side producer for one KRAM slot: accepts a valid/ready kernel-word stream and
// stripes it across the slot's PE_NUM banks (lane = i % PE_NUM, row = i / PE_NUM).
module kram_loader #(
  parameter int PE_NUM  = 8,
  parameter int DATA_W  = 16,
  parameter int BANK_AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                slot,
  input  logic [BANK_AW:0]    rows,
  input  logic                cu_slot,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  output logic [BANK_AW-1:0]  bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  output logic [2*PE_NUM-1:0] bram_we,
  output logic [2*PE_NUM-1:0] bram_en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // state | meaning
  // IDLE  | waiting for start; rejects loads into the slot the CU is reading
  // LOAD  | s_ready high, one registered bank write per handshake
  // LAST  | final write on the bus, done pulses, back to IDLE

  localparam int LANE_W = $clog2(PE_NUM);
  localparam int BANK_W = LANE_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_slot;
  logic [BANK_AW:0]    r_rows;
  logic [BANK_AW:0]    r_row;
  logic [LANE_W-1:0]   r_lane;

  logic                r_s_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [2*PE_NUM-1:0] r_we;
  logic [BANK_AW-1:0]  r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_req;
  logic                w_req_ok;
  logic                w_rows_zero;
  logic                w_hs;
  logic                w_lane_wrap;
  logic                w_last_word;
  logic [BANK_W-1:0]   w_bank;

  logic                w_s_ready_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_err_nxt;
  logic [2*PE_NUM-1:0] w_we_nxt;

  assign w_req       = start && (r_state == IDLE);
  assign w_req_ok    = w_req && (slot != cu_slot);
  assign w_rows_zero = (rows == '0);
  assign w_hs        = r_s_ready && s_valid;
  assign w_lane_wrap = (r_lane == LANE_W'(PE_NUM - 1));
  assign w_last_word = w_hs && w_lane_wrap && (r_row == (r_rows - (BANK_AW+1)'(1)));
  // PE_NUM is a power of two, so slot*PE_NUM + lane is a plain concatenation
  assign w_bank      = {r_slot, r_lane};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req_ok && !w_rows_zero) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (w_last_word) begin
          w_state_nxt = LAST;
        end
      end
      LAST:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; s_ready and busy follow the next state only.
  always_comb begin
    w_s_ready_nxt = (w_state_nxt == LOAD);
    w_busy_nxt    = (w_state_nxt != IDLE);
    w_done_nxt    = w_last_word || (w_req_ok && w_rows_zero);
    w_err_nxt     = w_req && (slot == cu_slot);
    w_we_nxt      = '0;
    for (int b = 0; b < 2*PE_NUM; b++) begin
      w_we_nxt[b] = w_hs && (w_bank == BANK_W'(b));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_we      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_s_ready <= w_s_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_we      <= w_we_nxt;
      if (w_hs) begin
        r_addr  <= r_row[BANK_AW-1:0];
        r_wdata <= s_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= 1'b0;
      r_rows <= '0;
      r_row  <= '0;
      r_lane <= '0;
    end else if (w_req_ok && !w_rows_zero) begin
      r_slot <= slot;
      r_rows <= rows;
      r_row  <= '0;
      r_lane <= '0;
    end else if (w_hs) begin
      r_lane <= r_lane + LANE_W'(1);
      if (w_lane_wrap) begin
        r_row <= r_row + (BANK_AW+1)'(1);
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign bram_we    = r_we;
  assign bram_en    = r_we;
  assign bram_addr  = r_addr;
  assign bram_wdata = r_wdata;

endmodule

// File: tb/tb_kram_loader.sv
// Directed bench for kram_loader with PE_NUM=4: bank contents are captured by a bus
// monitor and compared against hand-computed stripes.
module tb_kram_loader;
  localparam int PE_NUM  = 4;
  localparam int DATA_W  = 16;
  localparam int BANK_AW = 10;
  localparam int NB      = 2*PE_NUM;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              slot;
  logic [BANK_AW:0]  rows;
  logic              cu_slot;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [BANK_AW-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [NB-1:0]     bram_we;
  logic [NB-1:0]     bram_en;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  kram_loader #(.PE_NUM(PE_NUM), .DATA_W(DATA_W), .BANK_AW(BANK_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .slot(slot), .rows(rows), .cu_slot(cu_slot),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we), .bram_en(bram_en),
    .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt, viol_cnt, done_cnt, err_cnt;
  logic exp_slot;
  logic [DATA_W-1:0] mem [NB][1024];
  int got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Bank write capture plus bus-rule counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_en !== bram_we) viol_cnt++;
      if ($countones(bram_we) > 1) viol_cnt++;
      if ((bram_we & (exp_slot ? 8'h0F : 8'hF0)) != 8'h00) viol_cnt++;
      for (int b = 0; b < NB; b++) begin
        if (bram_we[b]) begin
          mem[b][bram_addr] = bram_wdata;
          wr_cnt++;
        end
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_cnt = 0; viol_cnt = 0; done_cnt = 0; err_cnt = 0;
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < 1024; r++)
        mem[b][r] = 16'hDEAD;
  endtask

  task automatic launch(input logic s, input logic [BANK_AW:0] r);
    slot = s; rows = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives n words base+i; gaps gives a 1010 valid pattern; at word inj a start is
  // injected with cu_slot moved onto the loading slot.
  task automatic send(input int n, input logic [15:0] base, input bit gaps, input int inj,
                      output int sent);
    int idx = 0;
    int cyc = 0;
    bit hs;
    while (idx < n && cyc < 3*n + 20) begin
      s_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      s_data  = base + 16'(idx);
      start   = (idx == inj);
      if (idx == inj) cu_slot = slot;
      hs = s_valid && s_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    sent    = idx;
  endtask

  task automatic check_stripe(input string tag, input logic [15:0] base);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_w%0d", tag, i), mem[4 + i % 4][i / 4], base + 16'(i));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; slot = 1'b0; rows = '0; cu_slot = 1'b0;
    s_valid = 1'b0; s_data = '0; exp_slot = 1'b1;
    clear_stats();
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: back-to-back load of slot 1, two rows
    clear_stats();
    launch(1'b1, 11'd2);
    chk("t1_busy_rise", busy, 1);
    chk("t1_ready_rise", s_ready, 1);
    send(8, 16'h10, 1'b0, -1, got);
    chk("t1_words", got, 8);
    chk("t1_done", done, 1);
    chk("t1_ready_last", s_ready, 0);
    chk("t1_last_we", bram_we, 8'h80);
    chk("t1_last_addr", bram_addr, 1);
    chk("t1_last_data", bram_wdata, 16'h17);
    tick();
    chk("t1_done_fall", done, 0);
    chk("t1_busy_fall", busy, 0);
    check_stripe("t1", 16'h10);
    chk("t1_wr_cnt", wr_cnt, 8);
    chk("t1_viol", viol_cnt, 0);

    // 2: same load with 1010 valid
    clear_stats();
    launch(1'b1, 11'd2);
    send(8, 16'h10, 1'b1, -1, got);
    chk("t2_words", got, 8);
    chk("t2_done", done, 1);
    tick();
    check_stripe("t2", 16'h10);
    chk("t2_wr_cnt", wr_cnt, 8);
    chk("t2_viol", viol_cnt, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: start into the slot the CU is reading
    clear_stats();
    cu_slot = 1'b0;
    launch(1'b0, 11'd2);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ready", s_ready, 0);
    chk("t3_we", bram_we, 0);
    tick();
    chk("t3_err_fall", err, 0);
    chk("t3_ready2", s_ready, 0);
    chk("t3_err_cnt", err_cnt, 1);

    // 4: zero-row load
    clear_stats();
    launch(1'b1, 11'd0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_ready", s_ready, 0);
    tick();
    chk("t4_done_fall", done, 0);
    chk("t4_ready2", s_ready, 0);
    chk("t4_wr_cnt", wr_cnt, 0);
    chk("t4_err_cnt", err_cnt, 0);

    // 5: reset after 3 words, then a fresh one-row load
    clear_stats();
    launch(1'b1, 11'd2);
    send(3, 16'h30, 1'b0, -1, got);
    chk("t5_words", got, 3);
    chk("t5_we_pre", bram_we, 8'h40);
    rst = 1'b1;
    #1;
    chk("t5_rst_we", bram_we, 0);
    chk("t5_rst_en", bram_en, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", s_ready, 0);
    chk("t5_rst_addr", bram_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    clear_stats();
    launch(1'b1, 11'd1);
    send(4, 16'h20, 1'b0, -1, got);
    chk("t5_words2", got, 4);
    chk("t5_done", done, 1);
    chk("t5_last_we", bram_we, 8'h80);
    chk("t5_last_addr", bram_addr, 0);
    tick();
    chk("t5_b4", mem[4][0], 16'h20);
    chk("t5_b5", mem[5][0], 16'h21);
    chk("t5_b6", mem[6][0], 16'h22);
    chk("t5_b7", mem[7][0], 16'h23);
    chk("t5_wr_cnt", wr_cnt, 4);
    chk("t5_done_cnt", done_cnt, 1);

    // 6: full-depth load into slot 0, start and cu_slot change mid-load
    clear_stats();
    cu_slot = 1'b1;
    exp_slot = 1'b0;
    launch(1'b0, 11'd1024);
    send(4096, 16'h0000, 1'b0, 100, got);
    chk("t6_words", got, 4096);
    chk("t6_done", done, 1);
    chk("t6_last_we", bram_we, 8'h08);
    chk("t6_last_addr", bram_addr, 10'h3FF);
    chk("t6_last_data", bram_wdata, 16'h0FFF);
    tick();
    chk("t6_busy_fall", busy, 0);
    chk("t6_done_fall", done, 0);
    chk("t6_b0_r0", mem[0][0], 16'h0000);
    chk("t6_b1_r512", mem[1][512], 16'h0801);
    chk("t6_b3_r1023", mem[3][1023], 16'h0FFF);
    chk("t6_wr_cnt", wr_cnt, 4096);
    chk("t6_viol", viol_cnt, 0);
    chk("t6_err_cnt", err_cnt, 0);
    chk("t6_done_cnt", done_cnt, 1);
    tick();
    tick();
    chk("t6_busy_idle", busy, 0);
    chk("t6_ready_idle", s_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
